// File: rtl/quad_enc_decoder.sv
// Quadrature A/B/Z receive decoder: 2-flop sync, per-channel glitch filter, 4x decode, wrapping position.
// Optional velocity gate (signed counts per P_VEL_WIN clocks) is built only with QENC_VEL_EN defined.
module quad_enc_decoder #(
  parameter int P_CPR      = 3600,
  parameter int P_POS_W    = 12,
  parameter int P_FILT_LEN = 4,
  parameter int P_VEL_WIN  = 100000
) (
  input  logic               I_CLK_100MHZ,
  input  logic               I_RST,
  input  logic               I_ENC_A,
  input  logic               I_ENC_B,
  input  logic               I_ENC_Z,
  input  logic               I_POS_CLR,
  input  logic               I_ERR_CLR,
  output logic [P_POS_W-1:0] O_POS,
  output logic               O_DIR,
  output logic               O_STEP,
  output logic               O_ERR,
  output logic               O_IDX_SEEN,
  output logic [P_POS_W-1:0] O_IDX_POS
`ifdef QENC_VEL_EN
  ,
  output logic signed [P_POS_W+3:0] O_VEL
`endif
);

  typedef enum logic [1:0] {AB00 = 2'b00, AB01 = 2'b01, AB10 = 2'b10, AB11 = 2'b11} ab_t;

  localparam logic [3:0]         FILT_MAX = 4'(P_FILT_LEN - 1);
  localparam logic [P_POS_W-1:0] CPR_MAX  = P_POS_W'(P_CPR - 1);

  if (((1 << P_POS_W) < P_CPR) || (P_FILT_LEN < 1) || (P_FILT_LEN > 15) || (P_VEL_WIN < 1)) begin : g_bad_cfg
    $error("quad_enc_decoder: illegal parameter combination");
  end

  // Channel bit order: [0]=A, [1]=B, [2]=Z
  logic [2:0]      sync1_q, sync2_q, filt_q;
  logic [2:0][3:0] fcnt_q;
  logic            z_prev_q;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {I_ENC_Z, I_ENC_B, I_ENC_A};
      sync2_q <= sync1_q;
      for (int ch = 0; ch < 3; ch++) begin
        if (sync2_q[ch] == filt_q[ch]) begin
          fcnt_q[ch] <= '0;
        end else if (fcnt_q[ch] == FILT_MAX) begin
          filt_q[ch] <= sync2_q[ch];
          fcnt_q[ch] <= '0;
        end else begin
          fcnt_q[ch] <= fcnt_q[ch] + 4'd1;
        end
      end
    end
  end

  ab_t                state_q, state_d, ab_in;
  logic               inc, dec, illegal, z_rise;
  logic [P_POS_W-1:0] pos_q, pos_d, idx_pos_q, idx_pos_d;
  logic               dir_q, dir_d, step_q, step_d, err_q, err_d, idx_seen_q, idx_seen_d;

  assign ab_in  = ab_t'({filt_q[0], filt_q[1]});
  assign z_rise = filt_q[2] & ~z_prev_q;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      state_q    <= AB00;
      z_prev_q   <= 1'b0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_seen_q <= 1'b0;
      idx_pos_q  <= '0;
    end else begin
      state_q    <= state_d;
      z_prev_q   <= filt_q[2];
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
      idx_seen_q <= idx_seen_d;
      idx_pos_q  <= idx_pos_d;
    end
  end

  always_comb begin
    state_d    = ab_in;
    inc        = 1'b0;
    dec        = 1'b0;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_d      = err_q;
    idx_seen_d = idx_seen_q;
    idx_pos_d  = idx_pos_q;
    unique case (state_q)
      AB00: begin inc = (ab_in == AB10); dec = (ab_in == AB01); end
      AB10: begin inc = (ab_in == AB11); dec = (ab_in == AB00); end
      AB11: begin inc = (ab_in == AB01); dec = (ab_in == AB10); end
      AB01: begin inc = (ab_in == AB00); dec = (ab_in == AB11); end
      default: ;
    endcase
    illegal = ((state_q ^ ab_in) == 2'b11);
    // A clear drops any concurrent step entirely, including its direction
    if (I_POS_CLR) begin
      pos_d = '0;
    end else if (inc) begin
      pos_d  = (pos_q == CPR_MAX) ? '0 : pos_q + 1'b1;
      dir_d  = 1'b1;
      step_d = 1'b1;
    end else if (dec) begin
      pos_d  = (pos_q == '0) ? CPR_MAX : pos_q - 1'b1;
      dir_d  = 1'b0;
      step_d = 1'b1;
    end
    if (illegal)        err_d = 1'b1;
    else if (I_ERR_CLR) err_d = 1'b0;
    if (z_rise) begin
      idx_pos_d  = pos_d;
      idx_seen_d = 1'b1;
    end
  end

  assign O_POS      = pos_q;
  assign O_DIR      = dir_q;
  assign O_STEP     = step_q;
  assign O_ERR      = err_q;
  assign O_IDX_SEEN = idx_seen_q;
  assign O_IDX_POS  = idx_pos_q;

`ifdef QENC_VEL_EN
  localparam int                   VW       = P_POS_W + 4;
  localparam int                   GW       = (P_VEL_WIN > 1) ? $clog2(P_VEL_WIN) : 1;
  localparam logic [GW-1:0]        GATE_END = GW'(P_VEL_WIN - 1);
  localparam logic signed [VW-1:0] V_ONE    = VW'(1);
  localparam logic signed [VW-1:0] V_MAX    = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN    = {1'b1, {(VW-1){1'b0}}};

  logic [GW-1:0]        gate_q, gate_d;
  logic signed [VW-1:0] acc_q, acc_d, vel_q, vel_d;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      gate_q <= '0;
      acc_q  <= '0;
      vel_q  <= '0;
    end else begin
      gate_q <= gate_d;
      acc_q  <= acc_d;
      vel_q  <= vel_d;
    end
  end

  always_comb begin
    gate_d = gate_q + 1'b1;
    acc_d  = acc_q;
    vel_d  = vel_q;
    if (step_d && dir_d && (acc_q != V_MAX))  acc_d = acc_q + V_ONE;
    if (step_d && !dir_d && (acc_q != V_MIN)) acc_d = acc_q - V_ONE;
    // Window end: publish, then restart counting from this cycle's step
    if (gate_q == GATE_END) begin
      gate_d = '0;
      vel_d  = acc_q;
      acc_d  = !step_d ? '0 : (dir_d ? V_ONE : -V_ONE);
    end
  end

  assign O_VEL = vel_q;
`endif

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder: latency, CW/CCW counting with wrap, glitch rejection,
// illegal transitions, index capture, position clear priority and reset mid-rotation.
module tb_quad_enc_decoder;
  logic        clk = 1'b0;
  logic        rst, a, b, z, pclr, eclr;
  logic [11:0] pos, idx_pos;
  logic        dir, step, err, idx_seen;
`ifdef QENC_VEL_EN
  logic signed [15:0] vel;
`endif
  int tests = 0, fails = 0, step_cnt = 0, sc;

  always #5 clk = ~clk;

  quad_enc_decoder dut (
    .I_CLK_100MHZ(clk), .I_RST(rst), .I_ENC_A(a), .I_ENC_B(b), .I_ENC_Z(z),
    .I_POS_CLR(pclr), .I_ERR_CLR(eclr),
    .O_POS(pos), .O_DIR(dir), .O_STEP(step), .O_ERR(err),
    .O_IDX_SEEN(idx_seen), .O_IDX_POS(idx_pos)
`ifdef QENC_VEL_EN
    , .O_VEL(vel)
`endif
  );

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive {A,B} just after an edge and advance n clocks, ending 1 ns past the last edge
  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cw(input int i);
    case (i % 4)
      0:       return 2'b10;
      1:       return 2'b11;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; z = 1'b0; pclr = 1'b0; eclr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", pos, 0);
    check("rst_dir", dir, 0);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_idx_seen", idx_seen, 0);
    check("rst_idx_pos", idx_pos, 0);
    rst = 1'b0;

    // First CW state: count must appear exactly P_FILT_LEN+3 = 7 clocks after the pin change
    hold(2'b10, 6);
    check("lat_pre_pos", pos, 0);
    check("lat_pre_step", step, 0);
    hold(2'b10, 1);
    check("lat_step", step, 1);
    check("lat_pos", pos, 1);
    for (int i = 1; i < 40; i++) hold(cw(i), 4);
    hold(2'b00, 10);
    check("cw40_pos", pos, 40);
    check("cw40_dir", dir, 1);
    check("cw40_steps", step_cnt, 40);
    check("cw40_err", err, 0);

    // CCW through zero
    pclr = 1'b1; hold(2'b00, 1); pclr = 1'b0;
    check("clr_pos", pos, 0);
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b11, 8);
    check("pos2", pos, 2);
    hold(2'b10, 4); hold(2'b00, 4); hold(2'b00, 8);
    check("ccw_zero", pos, 0);
    hold(2'b01, 4); hold(2'b01, 8);
    check("ccw_wrap", pos, 3599);
    hold(2'b11, 4); hold(2'b10, 4); hold(2'b10, 8);
    check("ccw_pos", pos, 3597);
    check("ccw_dir", dir, 0);

    // CW through the top, then a 2-clock glitch on A
    hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4); hold(2'b10, 4); hold(2'b10, 8);
    check("cw_wrap_pos", pos, 1);
    check("cw_wrap_dir", dir, 1);
    sc = step_cnt;
    hold(2'b00, 2); hold(2'b10, 10);
    check("glitch_pos", pos, 1);
    check("glitch_err", err, 0);
    check("glitch_steps", step_cnt, sc);

    // Illegal 00 -> 11 jump
    hold(2'b00, 4); hold(2'b00, 8);
    check("pre_ill_pos", pos, 0);
    hold(2'b11, 4); hold(2'b11, 8);
    check("ill_err", err, 1);
    check("ill_pos", pos, 0);
    check("ill_dir", dir, 0);
    hold(2'b01, 4); hold(2'b00, 4); hold(2'b00, 8);
    check("post_ill_pos", pos, 2);
    check("err_sticky", err, 1);
    eclr = 1'b1; hold(2'b00, 1); eclr = 1'b0;
    check("err_clr", err, 0);

    // Walk to 1234 and pulse Z
    for (int i = 0; i < 1232; i++) hold(cw(i), 4);
    hold(2'b00, 8);
    check("walk_pos", pos, 1234);
    check("pre_idx_seen", idx_seen, 0);
    z = 1'b1; hold(2'b00, 8); z = 1'b0; hold(2'b00, 8);
    check("idx_seen", idx_seen, 1);
    check("idx_pos", idx_pos, 1234);

    // I_POS_CLR landing on the same edge as a step
    sc = step_cnt;
    hold(2'b10, 6);
    pclr = 1'b1; hold(2'b10, 1);
    check("clr_step_pos", pos, 0);
    check("clr_step_step", step, 0);
    pclr = 1'b0; hold(2'b10, 8);
    check("clr_step_hold", pos, 0);
    check("clr_step_cnt", step_cnt, sc);
    check("clr_keeps_idx", idx_seen, 1);
    check("clr_keeps_idx_pos", idx_pos, 1234);

    // Reset mid-rotation: next filtered AB is judged against 00
    hold(2'b11, 3);
    rst = 1'b1; hold(2'b11, 1);
    check("rst2_idx_seen", idx_seen, 0);
    check("rst2_pos", pos, 0);
    rst = 1'b0; hold(2'b11, 10);
    check("rst2_ill_err", err, 1);
    check("rst2_ill_pos", pos, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_enc_decoder.md
Name: quad_enc_decoder

Overview:
- Receive-side decoder for the quadrature encoder A/B/Z interface on the JA header, running on the 100 MHz board clock.
- Synchronizes and glitch-filters A/B/Z, then decodes 4x quadrature.
- Maintains a wrapping position counter modulo counts-per-rev and reports direction, step pulses, illegal-transition errors and the index-pulse position.
- Feeds LED/status logic in top.

Parameters:
- P_CPR, 3600, counts per revolution after 4x decoding; position wraps modulo P_CPR.
- P_POS_W, 12, position width; must satisfy 2^P_POS_W >= P_CPR.
- P_FILT_LEN, 4, consecutive stable clocks required before a filtered input changes (range 1..15).
- P_VEL_WIN, 100000, velocity gate window in clocks (used only with QENC_VEL_EN).

Ports:
- I_CLK_100MHZ  in  1  system clock, 100 MHz
- I_RST  in  1  synchronous reset, active-high
- I_ENC_A  in  1  encoder phase A, asynchronous
- I_ENC_B  in  1  encoder phase B, asynchronous
- I_ENC_Z  in  1  encoder index, asynchronous
- I_POS_CLR  in  1  synchronous clear of O_POS to 0
- I_ERR_CLR  in  1  clears O_ERR
- O_POS  out  P_POS_W  current position, 0..P_CPR-1
- O_DIR  out  1  last valid step direction (1 = CW / increment, 0 = CCW)
- O_STEP  out  1  one-clock pulse per valid count
- O_ERR  out  1  sticky illegal-transition flag
- O_IDX_SEEN  out  1  sticky flag, set on first filtered Z rising edge
- O_IDX_POS  out  P_POS_W  O_POS value captured at the last Z rising edge
- O_VEL  out  P_POS_W+4  signed counts per gate window (QENC_VEL_EN only)

Behaviour:
- Reset (I_RST=1 at a clock edge): O_POS=0, O_DIR=0, O_STEP=0, O_ERR=0, O_IDX_SEEN=0, O_IDX_POS=0, O_VEL=0.
- Reset also clears sync flops, filter counters, filtered A/B/Z and the previous-AB state to 0.
- Reset mid-rotation takes effect on that edge; the next filtered AB change is decoded against AB=00.
- Synchronizer: 2 flops per input.
- Filter (independent per channel):
  - 4-bit counter clears whenever the synced sample differs from the candidate.
  - Filtered value updates when the candidate has been held P_FILT_LEN consecutive clocks.
  - Pulses shorter than P_FILT_LEN clocks are discarded.
- Decode FSM: state = previous filtered {A,B}.
  - CW sequence (+1): 10 -> 11 -> 01 -> 00 -> 10.
  - CCW sequence (-1): the reverse.
  - No change: hold.
  - Both bits changed: illegal. Set O_ERR, no count, O_DIR unchanged; the state still adopts the new AB.
- Count update:
  - +1 from P_CPR-1 wraps to 0; -1 from 0 wraps to P_CPR-1.
  - O_STEP=1 in the same clock O_POS changes; O_DIR is updated on the same edge.
- Latency: pin change to O_POS/O_STEP update = P_FILT_LEN+3 clocks (2 sync, P_FILT_LEN filter, 1 decode register).
- Index:
  - On a filtered Z 0->1 edge, O_IDX_POS <= position value in effect after that cycle's step, and O_IDX_SEEN <= 1.
  - Z high level has no further effect.
- Priority per clock: I_RST > I_POS_CLR > step.
  - I_POS_CLR concurrent with a step: O_POS=0, O_STEP=0, the step is dropped.
  - I_POS_CLR does not clear O_IDX_SEEN.
- I_ERR_CLR concurrent with a new illegal transition: O_ERR remains 1 (set wins).

Optional Feature:
- Macro QENC_VEL_EN.
- Defined:
  - Free-running gate counter of P_VEL_WIN clocks.
  - Signed accumulator +1/-1 per step.
  - At window end, O_VEL <= accumulator and the accumulator restarts with that cycle's step included.
  - Accumulator saturates at signed max/min.
- Undefined: O_VEL port, gate counter and accumulator are absent; no other behaviour changes.

Test Plan:
- Reset, then A/B stepped CW through 10,11,01,00 with 4 clocks per state for 40 states -> O_POS=40, O_DIR=1, 40 O_STEP pulses, O_ERR=0.
- From O_POS=2, step CCW 5 states -> O_POS=3597, O_DIR=0, wrap at 0 -> 3599.
- From O_POS=3598, 3 CW states -> O_POS=1; glitch of 2 clocks on A -> no count, no error.
- AB jump 00 -> 11 -> O_ERR=1, O_POS unchanged. Next CW steps count from AB=11. I_ERR_CLR pulse -> O_ERR=0.
- Z 8-clock pulse at O_POS=1234 -> O_IDX_SEEN=1, O_IDX_POS=1234. I_POS_CLR with a simultaneous step -> O_POS=0, O_STEP=0.
- QENC_VEL_EN with P_VEL_WIN=1000 and CW steps every 16 clocks -> O_VEL=62 or 63 per window; I_RST asserted mid-window -> O_VEL=0, window restarts.
